// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the processor front end: default bus widths, the
// opcode field location, the HALT opcode and the fetch FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package proc_pkg;

    // Default widths used by instr_fetch when its parameters are not overridden
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    // Opcode field of a 16-bit instruction word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    // Opcode that stops the fetch unit when HALT support is built in
    localparam logic [3:0] OPC_HALT = 4'hF;

    // Fetch FSM state, kept as plain constants so older tools and
    // waveform viewers see a simple 1-bit encoding
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t FETCH  = 1'b0;
    localparam fetch_state_t HALTED = 1'b1;

    // True when an instruction word carries the HALT opcode
    function automatic logic is_halt(input logic [DEF_DATA_W-1:0] word);
        return word[OPC_MSB:OPC_LSB] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// Two-entry FIFO that decouples instruction fetch from decode back-pressure.
// The head entry is always driven on head_data, so the output does not move
// until the entry is popped.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   push       write push_data this cycle
//   pop        remove the head entry this cycle
//   flush      discard all entries (wins over push and pop)
//   push_data  entry to write
//   head_data  oldest entry (reset value 0)
//   count      number of entries held, 0..2
//   empty      count == 0
// ---------------------------------------------------------------------------
module fetch_buf #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // Next-state logic for storage, pointers and occupancy. A push into a
    // full buffer is only accepted when the head leaves in the same cycle;
    // in that case the write lands in the slot being vacated.
    always_comb begin
        do_pop   = pop & (count_q != 2'd0);
        do_push  = push & ((count_q != 2'd2) | do_pop);
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (do_push) begin
                if (wr_ptr_q) begin
                    entry1_d = push_data;
                end else begin
                    entry0_d = push_data;
                end
                wr_ptr_d = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; entries clear on reset so the head reads as zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = rd_ptr_q ? entry1_q : entry0_q;
    assign count     = count_q;
    assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit. Owns the program counter, drives the registered
// program memory address, tracks the single outstanding read, buffers
// returned words in a 2-entry FIFO and hands them to decode over a
// valid/ready handshake. Redirects from execute flush everything in flight.
//
// Build option:
//   IFETCH_HALT_EN  when defined, a returned word with opcode 4'hF stops
//                   fetching (FSM enters HALTED, `halted` goes high). When
//                   undefined, `halted` is tied low and 4'hF is an ordinary
//                   instruction.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   pm_address      registered program memory address
//   pm_data         memory read data, valid the cycle after pm_address loads
//   instr           instruction at the head of the buffer
//   instr_pc        address of instr
//   instr_valid     instr/instr_pc hold a valid entry
//   instr_ready     decode accepts the head entry this cycle
//   redirect_valid  single-cycle branch/jump redirect request
//   redirect_addr   redirect target
//   halted          fetch has stopped on a HALT word
// ---------------------------------------------------------------------------
module instr_fetch
    import proc_pkg::*;
#(
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pm_address,
    input  logic [DATA_W-1:0] pm_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted
);

    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_q,          pc_d;
    logic [ADDR_W-1:0]  pm_address_q,  pm_address_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               rd_inflight_q, rd_inflight_d;

    logic               pop;
    logic               push;
    logic               issue;
    logic               fetching;
    logic               halt_hit;
    logic [2:0]         occupancy;
    logic [2:0]         limit;
    logic [1:0]         buf_count;
    logic               buf_empty;
    logic [ENTRY_W-1:0] buf_head;

`ifdef IFETCH_HALT_EN
    fetch_state_t       state_q, state_d;
`endif

    // Handshake and return path. A redirect flushes the buffer, so neither
    // a pop nor the cancelled read's return may take effect in that cycle.
    always_comb begin
        pop  = instr_valid & instr_ready & ~redirect_valid;
        push = rd_inflight_q & ~redirect_valid;
    end

`ifdef IFETCH_HALT_EN
    // HALT detection on the word being pushed, and the FSM gate on issuing
    always_comb begin
        halt_hit = push & is_halt(pm_data);
        fetching = (state_q == FETCH);
    end
`else
    // Without HALT support the unit is always fetching
    always_comb begin
        halt_hit = 1'b0;
        fetching = 1'b1;
    end
`endif

    // Issue decision. Entries already buffered plus the read coming back
    // must leave a free slot, counting the slot a pop frees this cycle. A
    // HALT return suppresses the read that would otherwise go out with it,
    // so the PC stays at the word after the HALT.
    always_comb begin
        occupancy = {1'b0, buf_count} + {2'b00, rd_inflight_q};
        limit     = 3'd2 + {2'b00, pop};
        issue     = fetching & ~redirect_valid & ~halt_hit & (occupancy < limit);
    end

    // Program counter, memory address and in-flight tracking. The in-flight
    // flag only lives for the single cycle in which its data comes back.
    always_comb begin
        pc_d          = pc_q;
        pm_address_d  = pm_address_q;
        inflight_pc_d = inflight_pc_q;
        rd_inflight_d = issue;
        if (redirect_valid) begin
            pc_d = redirect_addr;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(1);
            pm_address_d  = pc_q;
            inflight_pc_d = pc_q;
        end
    end

`ifdef IFETCH_HALT_EN
    // FSM: a redirect always returns to FETCH; a pushed HALT word parks it
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else if (halt_hit) begin
            state_d = HALTED;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == HALTED);
`else
    assign halted = 1'b0;
`endif

    // Fetch state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            pm_address_q  <= RESET_PC;
            inflight_pc_q <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pm_address_q  <= pm_address_d;
            inflight_pc_q <= inflight_pc_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    fetch_buf #(
        .WIDTH (ENTRY_W)
    ) u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data ({pm_data, inflight_pc_q}),
        .head_data (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign pm_address  = pm_address_q;
    assign instr       = buf_head[ADDR_W +: DATA_W];
    assign instr_pc    = buf_head[ADDR_W-1:0];
    assign instr_valid = ~buf_empty;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Scoreboard bench for instr_fetch. The reference model is the program
// order itself: starting from a PC, decode must see consecutive addresses
// with the memory word at each address, restarting at the target after a
// redirect and stopping after a HALT word when IFETCH_HALT_EN is defined.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] data;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  pm_address;
   logic [15:0] pm_data;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [7:0]  redirect_addr;
   logic        halted;

   logic [15:0] mem [256];
   exp_t        exp_q [$];
   logic [7:0]  model_pc;
   bit          model_halted;
   int          checks;
   int          errors;
   int          pops;

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .pm_address     (pm_address),
      .pm_data        (pm_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halted         (halted)
   );

   // Program memory: the registered pm_address acts as the memory's
   // address register, so data appears the cycle after it loads
   assign pm_data = mem[pm_address];

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison: counts it and reports a failure line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Keep a few upcoming program-order entries queued for the monitor
   task automatic topUp();
      exp_t e;
      while (exp_q.size() < 4 && !model_halted) begin
         e.pc   = model_pc;
         e.data = mem[model_pc];
         exp_q.push_back(e);
`ifdef IFETCH_HALT_EN
         if (mem[model_pc][15:12] == 4'hF) model_halted = 1'b1;
`endif
         model_pc = model_pc + 8'd1;
      end
   endtask

   // Program order restarts at a new address (reset release or redirect)
   task automatic modelRestart(input logic [7:0] addr);
      exp_q.delete();
      model_pc     = addr;
      model_halted = 1'b0;
      topUp();
   endtask

   // Drive one cycle of inputs shortly after the rising edge
   task automatic applyStimulus(input logic ready, input logic redir, input logic [7:0] addr);
      @(posedge clk);
      #2;
      instr_ready    = ready;
      redirect_valid = redir;
      redirect_addr  = addr;
      if (redir) modelRestart(addr);
      else topUp();
   endtask

   // Release reset with decode ready and check the first-instruction timing
   task automatic releaseAndCheckFirst(input string tag);
      @(posedge clk);
      #2;
      rst            = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      modelRestart(8'h00);
      @(negedge clk);
      checkOutput({tag, "_c1_valid"}, 32'(instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput({tag, "_c2_valid"}, 32'(instr_valid), 32'd0);
      checkOutput({tag, "_c2_pm_address"}, 32'(pm_address), 32'h00);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput({tag, "_c3_valid"}, 32'(instr_valid), 32'd1);
      checkOutput({tag, "_c3_instr_pc"}, 32'(instr_pc), 32'h00);
      checkOutput({tag, "_c3_instr"}, 32'(instr), 32'(mem[0]));
      checkOutput({tag, "_c3_pm_address"}, 32'(pm_address), 32'h01);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput({tag, "_c4_instr_pc"}, 32'(instr_pc), 32'h01);
      checkOutput({tag, "_c4_pm_address"}, 32'(pm_address), 32'h02);
   endtask

   // Monitor: every accepted handshake must match the head of the queue.
   // A pop coinciding with a redirect is discarded by the flush.
   always @(negedge clk) begin
      exp_t e;
      if (rst && instr_valid && instr_ready && !redirect_valid) begin
         pops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected: actual pc=%0h instr=%0h required no instruction", instr_pc, instr);
         end else begin
            e = exp_q.pop_front();
            checkOutput("sb_pc", 32'(instr_pc), 32'(e.pc));
            checkOutput("sb_instr", 32'(instr), 32'(e.data));
         end
      end
   end

   // Directed scenarios followed by a randomized run
   initial begin
      logic [7:0]  held_pm;
      logic [7:0]  held_pc;
      logic [15:0] held_instr;
      logic [7:0]  wrap_exp [4];
      int          pops0;

      checks         = 0;
      errors         = 0;
      pops           = 0;
      model_halted   = 1'b0;
      model_pc       = 8'h00;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      rst = 1'b1;
      #1 rst = 1'b0;
      #3;
      checkOutput("reset_pm_address", 32'(pm_address), 32'h00);
      checkOutput("reset_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("reset_instr", 32'(instr), 32'h0);
      checkOutput("reset_instr_pc", 32'(instr_pc), 32'h0);
      checkOutput("reset_halted", 32'(halted), 32'd0);

      $display("[TB] stream from reset");
      releaseAndCheckFirst("stream");
      repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);

      $display("[TB] back-pressure");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         @(negedge clk);
         checkOutput("bp_valid", 32'(instr_valid), 32'd1);
         if (k == 1) begin
            held_pm    = pm_address;
            held_pc    = instr_pc;
            held_instr = instr;
         end
         if (k == 4) begin
            checkOutput("bp_pm_address_frozen", 32'(pm_address), 32'(held_pm));
            checkOutput("bp_instr_pc_stable", 32'(instr_pc), 32'(held_pc));
            checkOutput("bp_instr_stable", 32'(instr), 32'(held_instr));
         end
      end
      repeat (6) applyStimulus(1'b1, 1'b0, 8'h00);

      $display("[TB] redirect with full buffer");
      repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b1, 8'h40);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("redir_r1_valid", 32'(instr_valid), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("redir_r2_valid", 32'(instr_valid), 32'd0);
      checkOutput("redir_r2_pm_address", 32'(pm_address), 32'h40);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("redir_r3_valid", 32'(instr_valid), 32'd1);
      checkOutput("redir_r3_instr_pc", 32'(instr_pc), 32'h40);
      checkOutput("redir_r3_instr", 32'(instr), 32'h1040);
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);

      $display("[TB] address wrap");
      wrap_exp[0] = 8'hFE;
      wrap_exp[1] = 8'hFF;
      wrap_exp[2] = 8'h00;
      wrap_exp[3] = 8'h01;
      applyStimulus(1'b1, 1'b1, 8'hFE);
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 8'h00);
         @(negedge clk);
         checkOutput("wrap_instr_pc", 32'(instr_pc), 32'(wrap_exp[k]));
      end

`ifdef IFETCH_HALT_EN
      $display("[TB] halt");
      @(posedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      mem[3] = 16'hF000;
      releaseAndCheckFirst("halt");
      repeat (8) applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("halt_halted", 32'(halted), 32'd1);
      checkOutput("halt_pm_address", 32'(pm_address), 32'h03);
      checkOutput("halt_drained", 32'(instr_valid), 32'd0);
      checkOutput("halt_all_delivered", 32'(exp_q.size()), 32'd0);
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("halt_pm_address_frozen", 32'(pm_address), 32'h03);
      applyStimulus(1'b1, 1'b1, 8'h10);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("halt_cleared", 32'(halted), 32'd0);
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("halt_resume_pc", 32'(instr_pc), 32'h10);
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
      mem[3] = 16'h1003;
`endif

      $display("[TB] async reset mid-stream");
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checkOutput("areset_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("areset_pm_address", 32'(pm_address), 32'h00);
      checkOutput("areset_halted", 32'(halted), 32'd0);
      exp_q.delete();
      for (int i = 0; i < 256; i++) begin
`ifdef IFETCH_HALT_EN
         mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
`else
         mem[i] = 16'($urandom);
`endif
      end
      releaseAndCheckFirst("restart");

      $display("[TB] randomized traffic");
      pops0 = pops;
      for (int c = 0; c < 600; c++) begin
         applyStimulus(logic'($urandom_range(0, 3) != 0),
                       logic'($urandom_range(0, 19) == 0),
                       8'($urandom));
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("random_progress", 32'((pops - pops0) > 150), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
